uart_cmd_parser: RTL and testbench

Consumes the byte stream produced by the UART receiver (8-bit data plus a one-cycle ready pulse). Parses ASCII command lines into control strobes and registers for the ultrasonic measurement controller. Produces a one-byte response code for the UART transmit path through a valid/ready handshake. Sits between the UART receiver and the sensor trigger/echo controller.

---
 rtl/uart_cmd_pkg.sv | 33 +++
 rtl/uart_cmd_parser_rsp_buffer.sv | 57 +++++
 rtl/uart_cmd_parser.sv | 184 ++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command parser.
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_M    = 8'h4D;
    localparam logic [7:0] ASCII_C    = 8'h43;
    localparam logic [7:0] ASCII_P    = 8'h50;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ONE  = 8'h31;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_K    = 8'h4B;
    localparam logic [7:0] ASCII_E    = 8'h45;
    localparam logic [7:0] ASCII_B    = 8'h42;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GOT_M     = 3'd1,
        ST_GOT_C     = 3'd2,
        ST_GOT_C_ARG = 3'd3,
        ST_GOT_P     = 3'd4,
        ST_DISCARD   = 3'd5
    } parser_state_e;

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/uart_cmd_parser_rsp_buffer.sv
// Single-entry response holding register; a response arriving while full
// and not draining is dropped and flagged on rsp_overrun.
module rsp_buffer (
    input  logic       clk,
    input  logic       reset,
    input  logic       gen_valid,
    input  logic [7:0] gen_data,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_valid,
    output logic       rsp_overrun
);

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;

    // Load / drain / overrun decision
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && rsp_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (gen_valid) begin
            if (valid_q && !rsp_ready) begin
                overrun_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                data_d  = gen_data;
            end
        end else begin
            overrun_d = 1'b0;
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign rsp_data    = data_q;
    assign rsp_valid   = valid_q;
    assign rsp_overrun = overrun_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command-line parser (M, C0/C1, P<digits>) driving the ultrasonic
// measurement controller and producing one response byte per line.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned MAX_DIGITS        = 5,
    parameter int unsigned MIN_PERIOD_MS     = 60,
    parameter int unsigned DEFAULT_PERIOD_MS = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        sensor_busy,
    output logic        measure_start,
    output logic        cont_enable,
    output logic [15:0] period_ms,
    output logic        period_update,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_overrun
);

    parser_state_e state_q, state_d;
    logic [19:0]   acc_q, acc_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          arg_q, arg_d;
    logic          measure_start_q, measure_start_d;
    logic          cont_enable_q, cont_enable_d;
    logic [15:0]   period_ms_q, period_ms_d;
    logic          period_update_q, period_update_d;
    logic          gen_valid_s;
    logic [7:0]    gen_data_s;
    logic          term_s;
    logic          period_ok_s;

    assign term_s      = is_term(rx_data);
    assign period_ok_s = (acc_q >= 20'(MIN_PERIOD_MS)) && (acc_q <= 20'd65535);

    // Parser next state, argument datapath and command execution
    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        cnt_d           = cnt_q;
        arg_d           = arg_q;
        measure_start_d = 1'b0;
        cont_enable_d   = cont_enable_q;
        period_ms_d     = period_ms_q;
        period_update_d = 1'b0;
        gen_valid_s     = 1'b0;
        gen_data_s      = ASCII_E;
        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == ASCII_M) begin
                        state_d = ST_GOT_M;
                    end else if (rx_data == ASCII_C) begin
                        state_d = ST_GOT_C;
                    end else if (rx_data == ASCII_P) begin
                        state_d = ST_GOT_P;
                        acc_d   = 20'd0;
                        cnt_d   = 4'd0;
                    end else if (term_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_GOT_M: begin
                    if (term_s) begin
                        state_d     = ST_IDLE;
                        gen_valid_s = 1'b1;
                        if (!sensor_busy) begin
                            measure_start_d = 1'b1;
                            gen_data_s      = ASCII_K;
                        end else begin
                            gen_data_s = ASCII_B;
                        end
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_GOT_C: begin
                    if ((rx_data == ASCII_ZERO) || (rx_data == ASCII_ONE)) begin
                        arg_d   = rx_data[0];
                        state_d = ST_GOT_C_ARG;
                    end else if (term_s) begin
                        state_d     = ST_IDLE;
                        gen_valid_s = 1'b1;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_GOT_C_ARG: begin
                    if (term_s) begin
                        state_d       = ST_IDLE;
                        cont_enable_d = arg_q;
                        gen_valid_s   = 1'b1;
                        gen_data_s    = ASCII_K;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_GOT_P: begin
                    if (is_digit(rx_data)) begin
                        if (cnt_q >= 4'(MAX_DIGITS)) begin
                            state_d = ST_DISCARD;
                        end else begin
                            acc_d = (acc_q * 20'd10) + {16'd0, rx_data[3:0]};
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (term_s) begin
                        state_d     = ST_IDLE;
                        gen_valid_s = 1'b1;
                        // An empty argument or out-of-range value keeps the old period
                        if ((cnt_q != 4'd0) && period_ok_s) begin
                            period_ms_d     = acc_q[15:0];
                            period_update_d = 1'b1;
                            gen_data_s      = ASCII_K;
                        end else begin
                            gen_data_s = ASCII_E;
                        end
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (term_s) begin
                        state_d     = ST_IDLE;
                        gen_valid_s = 1'b1;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Parser and control-output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            acc_q           <= 20'd0;
            cnt_q           <= 4'd0;
            arg_q           <= 1'b0;
            measure_start_q <= 1'b0;
            cont_enable_q   <= 1'b0;
            period_ms_q     <= 16'(DEFAULT_PERIOD_MS);
            period_update_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            arg_q           <= arg_d;
            measure_start_q <= measure_start_d;
            cont_enable_q   <= cont_enable_d;
            period_ms_q     <= period_ms_d;
            period_update_q <= period_update_d;
        end
    end

    assign measure_start = measure_start_q;
    assign cont_enable   = cont_enable_q;
    assign period_ms     = period_ms_q;
    assign period_update = period_update_q;

    rsp_buffer u_rsp_buffer (
        .clk         (clk),
        .reset       (reset),
        .gen_valid   (gen_valid_s),
        .gen_data    (gen_data_s),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_valid   (rsp_valid),
        .rsp_overrun (rsp_overrun)
    );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: directed command lines, expected
// response bytes queued at stimulus time and checked by a separate monitor.
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        sensor_busy = 1'b0;
    logic        measure_start;
    logic        cont_enable;
    logic [15:0] period_ms;
    logic        period_update;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_overrun;

    int checks = 0;
    int errors = 0;
    int ms_cnt = 0;
    int pu_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] exp_q[$];

    uart_cmd_parser dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .sensor_busy   (sensor_busy),
        .measure_start (measure_start),
        .cont_enable   (cont_enable),
        .period_ms     (period_ms),
        .period_update (period_update),
        .rsp_data      (rsp_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_overrun   (rsp_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: counts strobe cycles and scores every accepted response
    always @(negedge clk) begin
        if (!reset) begin
            if (measure_start) ms_cnt++;
            if (period_update) pu_cnt++;
            if (rsp_overrun)   ov_cnt++;
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got 0x%0h expected none", rsp_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rsp_data !== e) begin
                        errors++;
                        $display("FAIL rsp_data: got 0x%0h expected 0x%0h", rsp_data, e);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic cmd(input string s, input logic [7:0] rsp);
        exp_q.push_back(rsp);
        send_str(s);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || rsp_valid) begin
            errors++;
            $display("FAIL drain_%s: got %0d pending expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ms0, pu0, ov0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #2;
        chk("rst_measure_start", measure_start, 0);
        chk("rst_cont_enable", cont_enable, 0);
        chk("rst_period_ms", period_ms, 100);
        chk("rst_period_update", period_update, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_overrun", rsp_overrun, 0);

        // M with sensor idle; response must be held while rsp_ready is low
        ms0 = ms_cnt;
        rsp_ready = 1'b0;
        cmd("M\r", 8'h4B);
        chk("m_pulse_latency", measure_start, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("m_rsp_held_valid", rsp_valid, 1);
        chk("m_rsp_held_data", rsp_data, 8'h4B);
        rsp_ready = 1'b1;
        drain("m");
        chk("m_pulse_count", ms_cnt - ms0, 1);

        ms0 = ms_cnt;
        sensor_busy = 1'b1;
        cmd("M\r", 8'h42);
        drain("m_busy");
        chk("m_busy_no_pulse", ms_cnt - ms0, 0);
        sensor_busy = 1'b0;

        // Period argument range and digit-count limits
        pu0 = pu_cnt;
        cmd("P250\n", 8'h4B);
        chk("p250_update_latency", period_update, 1);
        drain("p250");
        chk("p250_period", period_ms, 250);
        chk("p250_update_count", pu_cnt - pu0, 1);
        pu0 = pu_cnt;
        cmd("P65536\n", 8'h45);
        cmd("P40\n", 8'h45);
        cmd("P123456\n", 8'h45);
        cmd("P\n", 8'h45);
        drain("p_err");
        chk("p_err_period", period_ms, 250);
        chk("p_err_no_update", pu_cnt - pu0, 0);
        cmd("P60\r", 8'h4B);
        drain("p60");
        chk("p60_period", period_ms, 60);
        cmd("P65535\r", 8'h4B);
        drain("p65535");
        chk("p65535_period", period_ms, 65535);
        cmd("P00080\r", 8'h4B);
        drain("p00080");
        chk("p00080_period", period_ms, 80);

        // Continuous mode
        cmd("C1\r\n", 8'h4B);
        drain("c1");
        chk("c1_cont", cont_enable, 1);
        cmd("C7\n", 8'h45);
        cmd("C\n", 8'h45);
        drain("c_err");
        chk("c_err_cont", cont_enable, 1);

        // Malformed lines
        ms0 = ms_cnt;
        pu0 = pu_cnt;
        cmd("X12\n", 8'h45);
        cmd("m\n", 8'h45);
        cmd("M5\n", 8'h45);
        cmd("\r\n\n", 8'h45);
        void'(exp_q.pop_back());
        drain("bad");
        chk("bad_no_measure", ms_cnt - ms0, 0);
        chk("bad_no_update", pu_cnt - pu0, 0);

        // Reset mid-line discards the partial P command
        pu0 = pu_cnt;
        send_str("P12");
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("rst_mid_period", period_ms, 100);
        chk("rst_mid_cont", cont_enable, 0);
        cmd("3\n", 8'h45);
        drain("rst_mid");
        chk("rst_mid_no_update", pu_cnt - pu0, 0);
        chk("rst_mid_period_after", period_ms, 100);

        // Overrun: second response dropped, command still executes
        cmd("C1\r", 8'h4B);
        drain("c1b");
        ms0 = ms_cnt;
        ov0 = ov_cnt;
        rsp_ready = 1'b0;
        cmd("M\r", 8'h4B);
        send_str("C0\r");
        repeat (2) @(posedge clk);
        #1;
        chk("ovr_count", ov_cnt - ov0, 1);
        chk("ovr_rsp_kept", rsp_data, 8'h4B);
        chk("ovr_rsp_valid", rsp_valid, 1);
        chk("ovr_cont", cont_enable, 0);
        // Accept the pending byte in the same cycle a new response is generated
        exp_q.push_back(8'h4B);
        send_byte(8'h4D);
        @(posedge clk); #1;
        rx_data   = 8'h0D;
        rx_valid  = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        chk("simul_new_valid", rsp_valid, 1);
        chk("simul_new_data", rsp_data, 8'h4B);
        drain("simul");
        chk("simul_no_overrun", ov_cnt - ov0, 1);
        chk("simul_measure", ms_cnt - ms0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
